// File: rtl/lc3_display_tx_if.sv
// lc3_display_tx_if: display-path bus between the LC-3 memory/I-O unit and the UART display transmitter
interface lc3_display_tx_if #(
    parameter int FIFO_AW = 2
);
    logic [15:0]      DDR;
    logic             WR_DDR;
    logic             CLR_OVF;
    logic             DSR_ready;
    logic             TXD;
    logic             tx_busy;
    logic [FIFO_AW:0] fifo_count;
    logic             overflow;
    modport master (
        output DDR, WR_DDR, CLR_OVF,
        input  DSR_ready, TXD, tx_busy, fifo_count, overflow
    );
    modport slave (
        input  DDR, WR_DDR, CLR_OVF,
        output DSR_ready, TXD, tx_busy, fifo_count, overflow
    );
endinterface

// File: rtl/lc3_display_tx.sv
// lc3_display_tx: buffers LC-3 display characters in a small FIFO and sends them as 8N1 UART on TXD
module lc3_display_tx #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 2
) (
    input logic             clk,
    input logic             reset,
    lc3_display_tx_if.slave bus
);
    localparam logic [FIFO_AW:0] DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [15:0]      DIV_LAST = 16'(CLK_DIV - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t             state, state_nxt;
    logic [7:0]         mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [15:0]        div, div_nxt;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               txd, push, pop, bit_end, ovf, ddr_unused;

    assign push       = bus.WR_DDR && count != DEPTH;
    assign pop        = state == IDLE && count != '0;
    assign bit_end    = div == DIV_LAST;
    assign ddr_unused = ^bus.DDR[15:8];

    // FIFO storage: only accepted pushes write; reads are gated by count so no reset is needed
    always_ff @(posedge clk) begin
        if (reset && push)
            mem[wr_ptr] <= bus.DDR[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow (a dropped write beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
            ovf    <= (bus.WR_DDR && !push) || (ovf && !bus.CLR_OVF);
        end
    end

    // Frame sequencer: the divider paces each bit and the state advances on its terminal count
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        if (state == IDLE) begin
            state_nxt = pop ? START : IDLE;
            shift_nxt = pop ? mem[rd_ptr] : shift;
        end else begin
            div_nxt = bit_end ? '0 : div + 16'd1;
            if (bit_end) begin
                case (state)
                    START: begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                    DATA: begin
                        state_nxt = bit_idx == 3'd7 ? STOP : DATA;
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = shift >> 1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // Sequencer registers; TXD follows the state being entered so the line level is registered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_nxt;
            div     <= div_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            txd     <= state_nxt == START ? 1'b0 : state_nxt == DATA ? shift_nxt[0] : 1'b1;
        end
    end

    assign bus.TXD        = txd;
    assign bus.tx_busy    = state != IDLE;
    assign bus.fifo_count = count;
    assign bus.DSR_ready  = count != DEPTH;
    assign bus.overflow   = ovf;
endmodule

// File: tb/tb_lc3_display_tx.sv
// tb_lc3_display_tx: vector table, directed corner sequences and random traffic against a frame-timing model
module tb_lc3_display_tx;
    localparam int D     = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lc3_display_tx_if #(.FIFO_AW(AW)) bus();
    lc3_display_tx #(.CLK_DIV(D), .FIFO_AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_vec = 0;
    int n_err = 0;

    // behavioural model: queue of bytes, plus the byte on the line and cycles since its pop edge
    logic [7:0] q[$];
    bit         m_busy = 0;
    int         m_t    = 0;
    logic [7:0] m_cur  = '0;
    bit         m_ovf  = 0;

    function automatic logic m_txd();
        if (!m_busy) return 1'b1;
        if (m_t < D) return 1'b0;
        if (m_t < 9 * D) return m_cur[(m_t - D) / D];
        return 1'b1;
    endfunction

    task automatic model_step();
        int n;
        bit do_pop;
        n = q.size();
        if (!reset) begin
            q.delete();
            m_busy = 0;
            m_t    = 0;
            m_ovf  = 0;
            return;
        end
        do_pop = !m_busy && n != 0;
        m_ovf  = (bus.WR_DDR && n == DEPTH) ? 1'b1 : bus.CLR_OVF ? 1'b0 : m_ovf;
        if (m_busy) begin
            m_t++;
            if (m_t == 10 * D) m_busy = 0;
        end
        if (do_pop) begin
            m_cur  = q.pop_front();
            m_busy = 1;
            m_t    = 0;
        end
        if (bus.WR_DDR && n < DEPTH) q.push_back(bus.DDR[7:0]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model {dsr,txd,busy,count,ovf}",
              {25'd0, bus.DSR_ready, bus.TXD, bus.tx_busy, bus.fifo_count, bus.overflow},
              {25'd0, q.size() != DEPTH, m_txd(), m_busy, 3'(q.size()), m_ovf});
    endtask

    // independent UART receiver sampling TXD at mid-bit
    int         cyc = 0;
    logic [7:0] rx[$];
    int         rx_start[$];
    int         rx_t = -1;
    logic [7:0] rx_sh = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (reset !== 1'b1) rx_t = -1;
        else if (rx_t < 0) begin
            if (bus.TXD === 1'b0) begin
                rx_t = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t >= D && rx_t < 9 * D && (rx_t % D) == D / 2) rx_sh = {bus.TXD, rx_sh[7:1]};
            if (rx_t == 9 * D + D / 2) begin
                rx.push_back(rx_sh);
                rx_t = -1;
            end
        end
    end

    typedef struct {
        logic rst; logic wr; logic [15:0] ddr; logic clr;
        logic dsr; logic txd; logic busy; logic [2:0] cnt; logic ovf;
    } vec_t;
    vec_t tbl[13];

    initial begin
        logic [9:0] pat;
        int         pct;
        reset       = 1'b0;
        bus.DDR     = '0;
        bus.WR_DDR  = 1'b0;
        bus.CLR_OVF = 1'b0;
        tbl = '{
            '{1'b0, 1'b1, 16'hFF41, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0},
            '{1'b0, 1'b1, 16'hFF41, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0},
            '{1'b0, 1'b1, 16'hFF41, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0},
            '{1'b1, 1'b1, 16'h0041, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0},
            '{1'b1, 1'b1, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0},
            '{1'b1, 1'b1, 16'h0043, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0},
            '{1'b1, 1'b1, 16'h0044, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0},
            '{1'b1, 1'b1, 16'h0045, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0},
            '{1'b1, 1'b1, 16'h0046, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0},
            '{1'b1, 1'b1, 16'h0047, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1},
            '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0}
        };
        for (int i = 0; i < 13; i++) begin
            reset       = tbl[i].rst;
            bus.WR_DDR  = tbl[i].wr;
            bus.DDR     = tbl[i].ddr;
            bus.CLR_OVF = tbl[i].clr;
            tick();
            check($sformatf("tbl[%0d] dsr", i), bus.DSR_ready, tbl[i].dsr);
            check($sformatf("tbl[%0d] txd", i), bus.TXD, tbl[i].txd);
            check($sformatf("tbl[%0d] busy", i), bus.tx_busy, tbl[i].busy);
            check($sformatf("tbl[%0d] count", i), bus.fifo_count, tbl[i].cnt);
            check($sformatf("tbl[%0d] ovf", i), bus.overflow, tbl[i].ovf);
        end
        bus.WR_DDR  = 1'b0;
        bus.CLR_OVF = 1'b0;

        // full FIFO, write on the pop edge is dropped
        for (int g = 0; g < 200 && bus.tx_busy; g++) tick();
        check("full+pop idle reached", bus.tx_busy, 1'b0);
        bus.WR_DDR = 1'b1;
        bus.DDR    = 16'h005A;
        tick();
        bus.WR_DDR = 1'b0;
        check("full+pop count", bus.fifo_count, 3);
        check("full+pop ovf", bus.overflow, 1'b1);
        check("full+pop busy", bus.tx_busy, 1'b1);
        for (int g = 0; g < 1000 && rx.size() < 5; g++) tick();
        check("fill rx count", rx.size(), 5);
        for (int i = 0; i < 5 && i < rx.size(); i++) check($sformatf("fill rx[%0d]", i), rx[i], 8'h41 + i);
        for (int g = 0; g < 200 && bus.tx_busy; g++) tick();

        // single character bit timing
        rx.delete();
        reset = 1'b0;
        tick();
        reset      = 1'b1;
        bus.DDR    = 16'hAB41;
        bus.WR_DDR = 1'b1;
        tick();
        bus.WR_DDR = 1'b0;
        check("single count after push", bus.fifo_count, 1);
        check("single busy after push", bus.tx_busy, 1'b0);
        tick();
        check("single count after pop", bus.fifo_count, 0);
        check("single busy after pop", bus.tx_busy, 1'b1);
        pat = {1'b1, 8'h41, 1'b0};
        for (int i = 0; i < 160; i++) begin
            check($sformatf("single txd cycle %0d", i), bus.TXD, pat[i / D]);
            tick();
        end
        check("single busy after frame", bus.tx_busy, 1'b0);
        check("single rx count", rx.size(), 1);
        if (rx.size() > 0) check("single rx byte", rx[0], 8'h41);

        // reset in the middle of data bit 3 with two bytes queued
        for (int i = 0; i < 3; i++) begin
            bus.DDR    = 16'h0055 + 16'(i * 17);
            bus.WR_DDR = 1'b1;
            tick();
        end
        bus.WR_DDR = 1'b0;
        for (int i = 0; i < 68; i++) tick();
        check("midreset queued", bus.fifo_count, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset txd", bus.TXD, 1'b1);
        check("midreset count", bus.fifo_count, 0);
        check("midreset busy", bus.tx_busy, 1'b0);
        check("midreset ovf", bus.overflow, 1'b0);
        for (int i = 0; i < 400; i++) begin
            tick();
            check("post-reset txd idle", bus.TXD, 1'b1);
        end

        // pointer wrap while streaming nine bytes paced by DSR_ready
        rx.delete();
        rx_start.delete();
        for (int k = 0; k < 9; k++) begin
            for (int g = 0; g < 400 && !bus.DSR_ready; g++) tick();
            bus.DDR    = 16'h0030 + 16'(k);
            bus.WR_DDR = 1'b1;
            tick();
            bus.WR_DDR = 1'b0;
        end
        for (int g = 0; g < 2000 && rx.size() < 9; g++) tick();
        check("wrap rx count", rx.size(), 9);
        for (int i = 0; i < 9 && i < rx.size(); i++) check($sformatf("wrap rx[%0d]", i), rx[i], 8'h30 + i);
        for (int i = 1; i < 9 && i < rx_start.size(); i++)
            check($sformatf("wrap start spacing %0d", i), rx_start[i] - rx_start[i-1], 10 * D + 1);
        check("wrap ovf", bus.overflow, 1'b0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            pct         = (i / 500) % 3 == 0 ? 3 : (i / 500) % 3 == 1 ? 15 : 60;
            reset       = $urandom_range(0, 299) != 0;
            bus.WR_DDR  = $urandom_range(0, 99) < pct;
            bus.DDR     = 16'($urandom);
            bus.CLR_OVF = $urandom_range(0, 19) == 0;
            tick();
        end
        reset       = 1'b1;
        bus.WR_DDR  = 1'b0;
        bus.CLR_OVF = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
